// File: rtl/subckt_gate_pkg.sv
// Shared definitions for the subckt_gate_pipe slice: combine modes, the
// per-bit combine function and the minimum legal pipeline depth.
package subckt_gate_pkg;

  localparam int unsigned MIN_DEPTH = 2;

  typedef enum logic [1:0] {
    MODE_LEGACY = 2'd0,
    MODE_ANDN   = 2'd1,
    MODE_XOR    = 2'd2,
    MODE_PASS   = 2'd3
  } mode_e;

  // One channel of the combine network; the legacy mode is the original NAND/AND subcircuit.
  function automatic logic combine(input mode_e mode, input logic a, input logic n,
                                   input logic c, input logic d);
    logic q;
    case (mode)
      MODE_LEGACY: q = ~n & ~(a & ~(c & d));
      MODE_ANDN:   q = a & ~n;
      MODE_XOR:    q = a ^ n;
      default:     q = a;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/subckt_pipe_stage.sv
// One valid/payload register slice; loads upstream whenever go is high,
// otherwise holds. Payload loads even when the incoming valid is low.
module subckt_pipe_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (go) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/subckt_gate_pipe.sv
// Bit-sliced DEPTH-stage gate pipeline with valid/ready flow control,
// per-beat combine mode and a saturating count of non-zero delivered beats.
module subckt_gate_pipe
  import subckt_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cnt_sat
);

  localparam int unsigned PW = 2 + 4 * WIDTH;

  logic [DEPTH:0]   vld;
  logic [DEPTH:1]   go;
  logic [PW-1:0]    pay [DEPTH];
  logic [1:0]       s_mode;
  logic [WIDTH-1:0] s_a, s_n, s_c, s_d;
  logic [WIDTH-1:0] res_d, res_q;
  logic [CNT_W-1:0] cnt_nxt;

  assign vld[0] = in_valid;
  assign pay[0] = {in_mode, in_a, in_n, in_c, in_d};

  // go[k] folded from the output end with a scalar accumulator so the vector never feeds itself.
  always_comb begin : advance
    logic g;
    go = '0;
    g  = !vld[DEPTH] || out_ready;
    go[DEPTH] = g;
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      g     = !vld[k] || g;
      go[k] = g;
    end
  end

  assign in_ready = go[1];

  for (genvar k = 1; k < DEPTH; k++) begin : g_stage
    subckt_pipe_stage #(.W(PW)) u_stage (
      .clk       (clk),
      .rst_n     (rst),
      .go        (go[k]),
      .in_valid  (vld[k-1]),
      .in_data   (pay[k-1]),
      .out_valid (vld[k]),
      .out_data  (pay[k])
    );
  end

  assign {s_mode, s_a, s_n, s_c, s_d} = pay[DEPTH-1];

  always_comb begin
    res_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      res_d[i] = combine(mode_e'(s_mode), s_a[i], s_n[i], s_c[i], s_d[i]);
  end

  subckt_pipe_stage #(.W(WIDTH)) u_last (
    .clk       (clk),
    .rst_n     (rst),
    .go        (go[DEPTH]),
    .in_valid  (vld[DEPTH-1]),
    .in_data   (res_d),
    .out_valid (vld[DEPTH]),
    .out_data  (res_q)
  );

  assign out_valid = vld[DEPTH];
  assign out_q     = vld[DEPTH] ? res_q : '0;

  always_comb begin
    cnt_nxt = hit_cnt;
    if (cnt_clr)
      cnt_nxt = '0;
    else if (out_valid && out_ready && (out_q != '0) && (hit_cnt != '1))
      cnt_nxt = hit_cnt + CNT_W'(1);
  end

  // cnt_sat tracks the registered count, so it is derived from the next value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt <= '0;
      cnt_sat <= 1'b0;
    end else begin
      hit_cnt <= cnt_nxt;
      cnt_sat <= (cnt_nxt == '1);
    end
  end

endmodule

// File: tb/tb_subckt_gate_pipe.sv
// Directed and randomized bench for subckt_gate_pipe (WIDTH=4, DEPTH=3, CNT_W=2)
// against a slot-occupancy reference model.
module tb_subckt_gate_pipe;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 3;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_mode = '0;
  logic [WIDTH-1:0] in_a = '0, in_n = '0, in_c = '0, in_d = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_q;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] hit_cnt;
  logic             cnt_sat;

  subckt_gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_n      (in_n),
    .in_c      (in_c),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .cnt_clr   (cnt_clr),
    .hit_cnt   (hit_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               v;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a, n, c, d;
  } beat_t;

  beat_t slot [1:DEPTH];
  int    m_cnt;
  int    checks = 0;
  int    failures = 0;
  bit    acc;
  int    idx;

  function automatic logic [WIDTH-1:0] ref_q(beat_t b);
    case (b.mode)
      2'd0:    return ~b.n & ~(b.a & ~(b.c & b.d));
      2'd1:    return b.a & ~b.n;
      2'd2:    return b.a ^ b.n;
      default: return b.a;
    endcase
  endfunction

  // Deepest slot that can take new data this cycle (0 = whole pipe stalled).
  function automatic int deepest_go();
    if (out_ready) return DEPTH;
    for (int k = DEPTH; k >= 1; k--)
      if (!slot[k].v) return k;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 1; k <= DEPTH; k++)
      slot[k] = '{v: 1'b0, mode: '0, a: '0, n: '0, c: '0, d: '0};
    m_cnt = 0;
  endtask

  task automatic drive(input bit vld, input logic [1:0] m, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] c,
                       input logic [WIDTH-1:0] d, input bit ordy, input bit clr);
    in_valid  = vld;
    in_mode   = m;
    in_a      = a;
    in_n      = n;
    in_c      = c;
    in_d      = d;
    out_ready = ordy;
    cnt_clr   = clr;
  endtask

  // Starts at posedge+1: checks settled outputs, then advances DUT and model one edge.
  task automatic cycle(output bit accepted);
    int    h;
    beat_t nb;
    #2;
    h = deepest_go();
    check("in_ready",  in_ready,  (h >= 1));
    check("out_valid", out_valid, slot[DEPTH].v);
    check("out_q",     out_q,     slot[DEPTH].v ? ref_q(slot[DEPTH]) : '0);
    check("hit_cnt",   hit_cnt,   m_cnt);
    check("cnt_sat",   cnt_sat,   (m_cnt == CNT_MAX));
    accepted = in_valid && (h >= 1);
    nb = '{v: in_valid, mode: in_mode, a: in_a, n: in_n, c: in_c, d: in_d};
    @(posedge clk);
    #1;
    if (cnt_clr)
      m_cnt = 0;
    else if (slot[DEPTH].v && out_ready && (ref_q(slot[DEPTH]) != '0) && (m_cnt < CNT_MAX))
      m_cnt++;
    for (int k = h; k >= 2; k--)
      slot[k] = slot[k-1];
    if (h >= 1)
      slot[1] = nb;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2'd0, '0, '0, '0, '0, ordy, 1'b0);
      cycle(acc);
    end
  endtask

  initial begin
    model_reset();
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_q",     out_q,     '0);
    check("rst_hit_cnt",   hit_cnt,   '0);
    check("rst_cnt_sat",   cnt_sat,   1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Legacy mode truth vectors.
    drive(1'b1, 2'd0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0); cycle(acc);
    drive(1'b1, 2'd0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0); cycle(acc);
    drive(1'b1, 2'd0, 4'b1111, 4'b1010, 4'b1111, 4'b1111, 1'b1, 1'b0); cycle(acc);
    idle(4, 1'b1);

    // Modes 1..3, then mode changing every beat back-to-back.
    drive(1'b1, 2'd1, 4'b1100, 4'b1010, '0, '0, 1'b1, 1'b0); cycle(acc);
    drive(1'b1, 2'd2, 4'b1100, 4'b1010, '0, '0, 1'b1, 1'b0); cycle(acc);
    drive(1'b1, 2'd3, 4'b1100, 4'b1010, '0, '0, 1'b1, 1'b0); cycle(acc);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i), 4'b1100, 4'b1010, 4'(i), 4'b0110, 1'b1, 1'b0);
      cycle(acc);
    end
    idle(4, 1'b1);

    // Backpressure: five beats, downstream stalled for four cycles.
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive(idx < 5, 2'd3, 4'(idx + 1), '0, '0, '0, cyc >= 4, 1'b0);
      cycle(acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", idx, 5);

    // Counter: saturation, zero-result beat, clear coincident with a hit.
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1, 1'b1); cycle(acc);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd3, 4'b1111, '0, '0, '0, 1'b1, 1'b0);
      cycle(acc);
    end
    idle(4, 1'b1);
    drive(1'b1, 2'd3, 4'b0000, '0, '0, '0, 1'b1, 1'b0); cycle(acc);
    idle(4, 1'b1);
    drive(1'b1, 2'd1, 4'b1111, 4'b0000, '0, '0, 1'b1, 1'b0); cycle(acc);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1, slot[DEPTH].v);
      cycle(acc);
    end

    // Asynchronous reset with two beats in flight.
    drive(1'b1, 2'd3, 4'b1111, '0, '0, '0, 1'b1, 1'b0); cycle(acc);
    drive(1'b1, 2'd3, 4'b0111, '0, '0, '0, 1'b1, 1'b0); cycle(acc);
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_q",     out_q,     '0);
    check("mid_rst_hit_cnt",   hit_cnt,   '0);
    check("mid_rst_cnt_sat",   cnt_sat,   1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(5, 1'b1);
    drive(1'b1, 2'd2, 4'b1001, 4'b0011, '0, '0, 1'b1, 1'b0); cycle(acc);
    idle(4, 1'b1);

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), ($urandom % 10) < 7, ($urandom % 25) == 0);
      cycle(acc);
    end
    idle(6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subckt_gate_pipe.md
Name: subckt_gate_pipe

Overview:
- Parametrised successor to the fixed two-register NAND/AND trojan-benchmark subcircuit.
- Bit-sliced over WIDTH channels with a DEPTH-stage registered pipeline and valid/ready flow control.
- Selectable combine mode, carried with each beat.
- Saturating activity counter of non-zero outputs, used as a trigger monitor in detection testbenches.

Parameters:
- WIDTH, 4, channels per beat (bit-sliced, channels independent); WIDTH >= 1
- DEPTH, 2, pipeline stages from accepted input to out_q; DEPTH >= 2
- CNT_W, 8, width of hit counter; CNT_W >= 1

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous reset, active-low
- in_valid  input  1  beat offered
- in_ready  output  1  pipeline can accept beat this cycle
- in_mode  input  2  combine mode for this beat
- in_a  input  WIDTH  registered-path operand
- in_n  input  WIDTH  inverted operand
- in_c  input  WIDTH  NAND operand 1
- in_d  input  WIDTH  NAND operand 2
- out_valid  output  1  out_q holds valid result
- out_ready  input  1  downstream accepts
- out_q  output  WIDTH  registered result
- cnt_clr  input  1  synchronous clear of hit_cnt
- hit_cnt  output  CNT_W  count of delivered beats with out_q != 0
- cnt_sat  output  1  hit_cnt is all-ones

Behaviour:
- Reset (rst=0, async): all stage valids 0, all stage data 0, out_valid=0, out_q=0, hit_cnt=0, cnt_sat=0. Release is synchronous to clk.
- Pipeline structure:
  - Stage k (1..DEPTH) holds v[k] plus a payload.
  - Stages 1..DEPTH-1 carry {mode,a,n,c,d}.
  - Stage DEPTH holds the result; out_valid=v[DEPTH], out_q=data[DEPTH].
- Advance rule:
  - go[DEPTH] = !v[DEPTH] | out_ready.
  - go[k] = !v[k] | go[k+1].
  - in_ready = go[1], combinational, no dependency on in_valid.
  - Stage k loads stage k-1 (stage 1 loads inputs) when go[k]. New v[k] = v[k-1] (in_valid for k=1).
  - Bubbles collapse; full throughput is 1 beat/cycle.
- Latency: beat accepted at edge t appears on out_q/out_valid after edge t+DEPTH-1 with no stall. Minimum latency is DEPTH cycles from input presentation.
- Combine, computed on stage DEPTH-1 payload and registered into stage DEPTH, per bit:
  - mode 0: q = ~n & ~(a & ~(c & d))  (legacy function)
  - mode 1: q = a & ~n
  - mode 2: q = a ^ n
  - mode 3: q = a  (pass-through)
- Mode is captured per beat. Changing in_mode while beats are in flight affects only later beats.
- Hold: when v[k]=1 and !go[k], payload and valid are held unchanged.
- Data while invalid: stage data loads regardless of valid (don't care), but out_q is forced to 0 when out_valid=0.
- Counter:
  - On edge with out_valid & out_ready & (out_q != 0), hit_cnt increments, saturating at 2^CNT_W-1.
  - cnt_clr has priority over increment (result 0).
  - cnt_sat is registered: cnt_sat = (hit_cnt == all-ones).
- Simultaneous in/out handshakes on a full pipeline: allowed, no lost or duplicated beat.
- Reset mid-operation: in-flight beats are discarded, counter is zeroed, and nothing is emitted after release until new input arrives.

Decomposition:
- Package subckt_gate_pkg:
  - mode enum MODE_LEGACY=0, MODE_ANDN=1, MODE_XOR=2, MODE_PASS=3
  - function combine(mode,a,n,c,d)
  - MIN_DEPTH=2 constant
- Sub-module subckt_pipe_stage: one valid/payload register slice with go input, async active-low reset. Instantiated DEPTH times via generate, with the last instance fed by combine().

Test Plan (WIDTH=4, DEPTH=3, CNT_W=2):
- Mode 0 truth: a=1111,n=0000,c=1111,d=1111 -> out_q=1111. Then a=1111,c=0000 -> 0000. Then n=1010 with first vector -> 0101. Each appears 3 cycles after presentation.
- Modes 1-3 with a=1100,n=1010 -> 0100, 0110, 1100. Mode toggled every beat with back-to-back input -> results match per-beat mode, 1 beat/cycle.
- Backpressure: stream 5 beats, out_ready=0 for 4 cycles -> in_ready drops after 3 accepted beats, out_q held stable, no loss or duplication, order preserved after release.
- Counter:
  - 4 non-zero beats -> hit_cnt 1,2,3,3, cnt_sat=1.
  - Zero-result beat -> no increment.
  - cnt_clr coincident with hit -> hit_cnt=0.
- Reset mid-stream: rst=0 asynchronously with 2 beats in flight -> out_valid=0, out_q=0, hit_cnt=0 immediately. After release, no output until a new beat is accepted.
